// File: rtl/mult_booth_param.sv
`default_nettype none
// ============================================================================
// Module      : mult_booth_param
// Description : Sequential radix-2 Booth multiplier, N-bit operands, 2N-bit
//               product, signed/unsigned per operation, fixed N+1 iterations.
// Revision    : 1.0
// ============================================================================
module mult_booth_param #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signo,
    input  logic [N-1:0]   valorQ,
    input  logic [N-1:0]   valorM,
    output logic [2*N-1:0] producto,
    output logic           fin,
    output logic           busy
);

    localparam int CW = $clog2(N + 2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_done;

    logic [N:0]       r_a;
    logic [N:0]       r_q;
    logic             r_q1;
    logic [N:0]       r_m;
    logic [CW-1:0]    r_count;
    logic [2*N-1:0]   r_producto;
    logic             r_fin;
    logic             r_busy;

    logic [N:0]       w_sum;
    logic [N:0]       w_q_ext;
    logic [N:0]       w_m_ext;

    // One extra bit keeps -2^(N-1) and 2^N-1 representable in both modes.
    assign w_q_ext = {signo & valorQ[N-1], valorQ};
    assign w_m_ext = {signo & valorM[N-1], valorM};

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (r_count == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_q        <= '0;
            r_q1       <= 1'b0;
            r_m        <= '0;
            r_count    <= '0;
            r_producto <= '0;
            r_fin      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fin   <= w_done;
            if (w_load) begin
                r_a     <= '0;
                r_q     <= w_q_ext;
                r_q1    <= 1'b0;
                r_m     <= w_m_ext;
                r_count <= CW'(N + 1);
                r_busy  <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_a     <= {w_sum[N], w_sum[N:1]};
                r_q     <= {w_sum[0], r_q[N:1]};
                r_q1    <= r_q[0];
                r_count <= r_count - CW'(1);
                if (w_done) begin
                    // Low 2N bits of the post-shift {A,Q}.
                    r_producto <= {w_sum[N-1:0], r_q[N:1]};
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign producto = r_producto;
    assign fin      = r_fin;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_booth_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_booth_param
// Description : Scoreboard bench for mult_booth_param at N=4 and N=8.
// Revision    : 1.0
// ============================================================================
module tb_mult_booth_param;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start4, signo4, fin4, busy4;
    logic [3:0]  q4, m4;
    logic [7:0]  producto4;
    logic        start8, signo8, fin8, busy8;
    logic [7:0]  q8, m8;
    logic [15:0] producto8;

    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb4[$];
    exp_t sb8[$];

    mult_booth_param #(.N(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .signo(signo4),
        .valorQ(q4), .valorM(m4), .producto(producto4), .fin(fin4), .busy(busy4)
    );

    mult_booth_param #(.N(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .signo(signo8),
        .valorQ(q8), .valorM(m8), .producto(producto8), .fin(fin8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitors: pop on every fin, flag late or unexpected results.
    always @(negedge clk) begin
        if (fin4) begin
            n_checks++;
            if (sb4.size() == 0) begin
                n_fail++;
                $display("FAIL n4_unexpected_fin: producto=%h at cycle %0d", producto4, cyc);
            end else begin
                exp_t e;
                e = sb4.pop_front();
                if (producto4 !== e.prod[7:0] || cyc != e.cyc || busy4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL n4_result: producto=%h cyc=%0d busy=%b, expected %h cyc=%0d busy=0",
                             producto4, cyc, busy4, e.prod[7:0], e.cyc);
                end
            end
        end else if (sb4.size() > 0 && cyc > sb4[0].cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL n4_timeout: no fin by cycle %0d, expected %h", sb4[0].cyc, sb4[0].prod[7:0]);
            void'(sb4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (fin8) begin
            n_checks++;
            if (sb8.size() == 0) begin
                n_fail++;
                $display("FAIL n8_unexpected_fin: producto=%h at cycle %0d", producto8, cyc);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                if (producto8 !== e.prod || cyc != e.cyc || busy8 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL n8_result: producto=%h cyc=%0d busy=%b, expected %h cyc=%0d busy=0",
                             producto8, cyc, busy8, e.prod, e.cyc);
                end
            end
        end else if (sb8.size() > 0 && cyc > sb8[0].cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL n8_timeout: no fin by cycle %0d, expected %h", sb8[0].cyc, sb8[0].prod);
            void'(sb8.pop_front());
        end
    end

    // Start pulse on the N=4 unit; fin expected at the negedge after E0+5.
    task automatic issue4(input logic sg, input logic [3:0] q, input logic [3:0] m,
                          input logic [7:0] req);
        exp_t e;
        @(negedge clk);
        start4 = 1'b1; signo4 = sg; q4 = q; m4 = m;
        e.prod = {8'h00, req};
        e.cyc  = cyc + 6;
        sb4.push_back(e);
        @(negedge clk);
        start4 = 1'b0; q4 = 4'h0; m4 = 4'h0; signo4 = 1'b0;
        check("n4_busy_after_start", {15'd0, busy4}, 16'd1);
    endtask

    task automatic push8(input logic sg, input logic [7:0] q, input logic [7:0] m,
                         input logic [15:0] req);
        exp_t e;
        start8 = 1'b1; signo8 = sg; q8 = q; m8 = m;
        e.prod = req;
        e.cyc  = cyc + 10;
        sb8.push_back(e);
    endtask

    initial begin
        int bc;
        int waited;
        cyc = 0; n_checks = 0; n_fail = 0;
        reset = 1'b1;
        start4 = 1'b0; signo4 = 1'b0; q4 = '0; m4 = '0;
        start8 = 1'b0; signo8 = 1'b0; q8 = '0; m8 = '0;

        @(negedge clk);
        check("reset_producto4", {8'h00, producto4}, 16'h0000);
        check("reset_fin_busy4", {14'd0, fin4, busy4}, 16'd0);
        check("reset_producto8", producto8, 16'h0000);
        reset = 1'b0;

        // 3 x 2 unsigned, busy width, hold after completion
        issue4(1'b0, 4'b0011, 4'b0010, 8'd6);
        bc = 1;
        repeat (5) begin
            @(negedge clk);
            if (busy4) bc++;
        end
        check("n4_busy_cycles", 16'(bc), 16'd5);
        repeat (4) @(negedge clk);
        check("n4_producto_holds", {8'h00, producto4}, 16'd6);

        // signed and extreme operands
        issue4(1'b1, 4'b1101, 4'b0010, 8'hFA); repeat (6) @(negedge clk);
        issue4(1'b1, 4'b1000, 4'b1000, 8'h40); repeat (6) @(negedge clk);
        issue4(1'b0, 4'hF, 4'hF, 8'hE1);       repeat (6) @(negedge clk);
        issue4(1'b1, 4'hF, 4'hF, 8'h01);       repeat (6) @(negedge clk);
        issue4(1'b1, 4'b0111, 4'b1000, 8'hC8); repeat (6) @(negedge clk);

        // start while busy is ignored
        issue4(1'b0, 4'b0011, 4'b0010, 8'd6);
        start4 = 1'b1; q4 = 4'hF; m4 = 4'hF; signo4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (8) @(negedge clk);

        // asynchronous reset mid-operation
        issue4(1'b0, 4'hF, 4'hE, 8'hD2);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        sb4.delete();
        #1;
        check("n4_async_reset_out", {6'd0, fin4, busy4, producto4}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("n4_no_fin_after_reset", {8'h00, producto4}, 16'h0000);
        issue4(1'b0, 4'd7, 4'd5, 8'd35); repeat (6) @(negedge clk);

        // N=8 back-to-back through the fin cycle
        @(negedge clk);
        push8(1'b1, 8'h80, 8'h7F, 16'hC080);
        @(negedge clk);
        start8 = 1'b0; q8 = '0; m8 = '0;
        waited = 0;
        while (!fin8 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("n8_fin_seen", {15'd0, fin8}, 16'd1);
        push8(1'b0, 8'h02, 8'h03, 16'h0006);
        @(negedge clk);
        start8 = 1'b0; q8 = '0; m8 = '0;
        check("n8_busy_back_to_back", {15'd0, busy8}, 16'd1);
        repeat (12) @(negedge clk);

        check("sb4_drained", 16'(sb4.size()), 16'd0);
        check("sb8_drained", 16'(sb8.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mult_booth_param.md
Name: mult_booth_param

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the next generation of the team's 4-bit `mult` block and adds these features:
- generic operand width N
- per-operation signed/unsigned mode
- a `busy` status output
- asynchronous reset
- fixed, width-determined latency

It sits in the datapath as a multicycle arithmetic unit that is started by a single-cycle `start` pulse and completes with a single-cycle `fin` pulse.

Parameters:
N, 4, operand width in bits (N >= 2); the product is 2N bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only while idle
signo  input  1  mode select: 1 = two's-complement signed operands, 0 = unsigned; sampled with start
valorQ  input  N  multiplier; sampled with start
valorM  input  N  multiplicand; sampled with start
producto  output  2N  registered product; holds its value until the next completion
fin  output  1  one-cycle completion pulse; `producto` is valid while `fin` is high
busy  output  1  high while an operation is in progress

Behaviour:
Reset:
- While `reset` is high: state=IDLE; `producto`=0, `fin`=0, `busy`=0; internal A, Q, q_1, M and count all 0.
- Reset asserted mid-operation aborts the operation. No `fin` pulse is issued and `producto` reads 0.

State machine:
- States: IDLE and RUN.
- Extension: operands are extended to N+1 bits. Signed mode (signo=1) uses sign extension; unsigned mode (signo=0) uses zero extension. Every operation therefore uses N+1 iterations in both modes.

IDLE:
- `start`=1 at rising edge E0 loads: A=0 (N+1 bits), Q=ext(valorQ), q_1=0, M=ext(valorM), count=N+1.
- At the same edge: `busy`<=1, state<=RUN.
- `start`=0: remain in IDLE.

RUN, at each rising edge:
- Examine {Q[0],q_1}:
  - 01: A = A + M
  - 10: A = A - M
  - 00 or 11: A unchanged
- All arithmetic is modulo 2^(N+1).
- Then arithmetically shift {A,Q,q_1} right by one; A's MSB is replicated.
- Then count = count - 1.

Completion:
- Completion happens at the edge that performs the final iteration (count 1 -> 0), i.e. edge E0+N+1.
- At that edge: `producto` <= low 2N bits of the post-shift {A,Q}; `fin`<=1; `busy`<=0; state<=IDLE.
- Latency: `fin` is high during the cycle following edge E0+N+1. For N=4, that is 5 edges after the start edge.
- `fin` is forced to 0 at every other edge, so it is exactly one cycle wide.

Boundary conditions:
- `start` while busy: ignored. Operands and mode are not resampled, and the current operation is unaffected.
- `start` high in the cycle where `fin` is high: accepted, because the block is already IDLE. `busy` rises at that edge (back-to-back throughput of N+1 cycles per result).
- Operand inputs may change freely after the start edge.
- Signed extreme cases (-2^(N-1) as either or both operands) must be exact. N+1-bit internal precision guarantees this.
- Unsigned maximum (2^N-1)^2 must be exact and fit in 2N bits.
- `start` held high continuously: a new operation starts on each IDLE edge, giving repeated results every N+1 cycles.

Test Plan:
1. N=4, signo=0, valorQ=4'b0011, valorM=4'b0010, start pulsed for one cycle -> `busy`=1 for 5 cycles; then `fin`=1 for one cycle with producto=8'd6; `producto` holds 6 afterwards.
2. N=4, signo=1, valorQ=4'b1101 (-3), valorM=4'b0010 -> producto=8'hFA (-6). Separately, signo=1, valorQ=valorM=4'b1000 -> producto=8'h40 (+64).
3. N=4, signo=0, valorQ=valorM=4'hF -> producto=8'hE1 (225). Same operands with signo=1 -> producto=8'h01.
4. Start a 3x2 unsigned operation; on cycle 2 pulse start with valorQ=4'hF -> ignored; the single `fin` pulse carries producto=8'd6 at the original latency.
5. Assert `reset` asynchronously at mid-edge, 2 cycles into an operation -> `busy`, `fin` and `producto` go to 0 immediately; no `fin` after reset release. A fresh start then completes normally.
6. N=8, signo=1, valorQ=8'h80 (-128), valorM=8'h7F (127) -> `fin` 9 edges after start with producto=16'hC080. Assert start again in the `fin` cycle with 8'h02 x 8'h03 -> a second `fin` 9 edges later with producto=16'h0006.
